// File: rtl/metronome_skew_pkg.sv
// Shared constants and helpers for the skewed valid-strobe metronome.
package metronome_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic [31:0] clamp_len(logic [31:0] cfg, logic [31:0] max_len);
        return (cfg > max_len) ? max_len : cfg;
    endfunction

endpackage

// File: rtl/metronome_skew_if.sv
// Host/PE-array strobe bundle for metronome_skew.
interface metronome_skew_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 5
);
    logic              device_in_valid;
    logic              stall;
    logic [CNT_W-1:0]  cfg_len;
    logic [NUM_CH-1:0] data_in_valid;
    logic [NUM_CH-1:0] data_in_last;
    logic [NUM_CH-1:0] data_out_valid;
    logic [NUM_CH-1:0] data_out_last;
    logic [CNT_W-1:0]  last_count;
    logic              busy;

    modport master (
        output device_in_valid, stall, cfg_len,
        input  data_in_valid, data_in_last, data_out_valid, data_out_last, last_count, busy
    );

    modport slave (
        input  device_in_valid, stall, cfg_len,
        output data_in_valid, data_in_last, data_out_valid, data_out_last, last_count, busy
    );
endinterface

// File: rtl/metronome_skew_delay.sv
// Enable-gated shift register exposing every stage; stage 0 is d delayed one cycle.
module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [WIDTH-1:0]             d,
    output logic [DEPTH-1:0][WIDTH-1:0]  q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q[0] <= d;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
        end
    end
endmodule

// File: rtl/metronome_skew.sv
// Vector-length valid-strobe generator: channel-0 beats, per-channel skew, and
// PE-latency-aligned result strobes, all frozen and masked by stall.
module metronome_skew
    import metronome_pkg::*;
#(
    parameter int  MAX_LEN  = 16,
    parameter int  NUM_CH   = 4,
    parameter int  PIPE_LAT = 3,
    localparam int CNT_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    metronome_skew_if.slave  bus
);
    localparam int SKEW_D = (NUM_CH > 1) ? NUM_CH - 1 : 1;

    logic [1:0]                            state;
    logic [CNT_W-1:0]                      len, count, last_count;
    logic                                  v0, l0;
    logic                                  en, start, at_end, load, pending;
    logic [CNT_W-1:0]                      cfg_clamped;
    logic [NUM_CH-1:0][1:0]                din, dout;
    logic [SKEW_D-1:0][1:0]                skew_q;
    logic [NUM_CH-1:0][PIPE_LAT-1:0][1:0]  lat_q;

    assign en          = ~bus.stall;
    assign cfg_clamped = CNT_W'(clamp_len(32'(bus.cfg_len), 32'(MAX_LEN)));
    assign start       = bus.device_in_valid && (bus.cfg_len != '0);
    assign at_end      = (count == len - CNT_W'(1));
    // A new vector loads from idle or seamlessly at the final beat of the current one.
    assign load        = start && ((state == ST_IDLE) || ((state == ST_RUN) && at_end));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            len        <= '0;
            count      <= '0;
            last_count <= '0;
            v0         <= 1'b0;
            l0         <= 1'b0;
        end else if (en) begin
            v0 <= 1'b0;
            l0 <= 1'b0;
            if (load) begin
                state      <= ST_RUN;
                len        <= cfg_clamped;
                count      <= '0;
                last_count <= '0;
                v0         <= 1'b1;
                l0         <= (cfg_clamped == CNT_W'(1));
            end else begin
                case (state)
                    ST_RUN: begin
                        if (at_end) begin
                            state <= ST_DRAIN;
                        end else begin
                            count      <= count + CNT_W'(1);
                            last_count <= count + CNT_W'(1);
                            v0         <= 1'b1;
                            l0         <= (count + CNT_W'(1) == len - CNT_W'(1));
                        end
                    end
                    ST_DRAIN: if (!pending) state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    if (NUM_CH > 1) begin : g_skew
        valid_delay_line #(.DEPTH(NUM_CH - 1), .WIDTH(2)) u_skew (
            .clk(clk), .rst(rst), .en(en), .d({l0, v0}), .q(skew_q)
        );
    end else begin : g_noskew
        assign skew_q = '0;
    end

    always_comb begin
        din    = '0;
        din[0] = {l0, v0};
        for (int k = 1; k < NUM_CH; k++) din[k] = skew_q[k-1];
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lat
        valid_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(2)) u_lat (
            .clk(clk), .rst(rst), .en(en), .d(din[k]), .q(lat_q[k])
        );
        assign dout[k] = lat_q[k][PIPE_LAT-1];
    end

    // Idle may be entered once nothing remains that would still shift into an output.
    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            pending = pending | din[k][0];
            for (int s = 0; s < PIPE_LAT - 1; s++) pending = pending | (|lat_q[k][s]);
        end
    end

    always_comb begin
        bus.data_in_valid  = '0;
        bus.data_in_last   = '0;
        bus.data_out_valid = '0;
        bus.data_out_last  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.data_in_valid[k]  = din[k][0]  & en;
            bus.data_in_last[k]   = din[k][1]  & en;
            bus.data_out_valid[k] = dout[k][0] & en;
            bus.data_out_last[k]  = dout[k][1] & en;
        end
    end

    assign bus.last_count = last_count;
    assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_metronome_skew.sv
// Directed bench for metronome_skew; expectations come from hand-placed beat tables.
module tb_metronome_skew;
    localparam int MAX_LEN  = 16;
    localparam int NUM_CH   = 4;
    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = $clog2(MAX_LEN + 1);
    localparam int TAIL     = NUM_CH - 1 + PIPE_LAT;
    localparam int SW       = 4 * NUM_CH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    metronome_skew_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    metronome_skew #(.MAX_LEN(MAX_LEN), .NUM_CH(NUM_CH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_lc = 0;

    // Channel-0 beat table indexed by advancing-cycle number within a test.
    bit bv [0:255];
    bit bl [0:255];
    bit bz [0:255];
    int li [0:255];

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            bv[i] = 1'b0; bl[i] = 1'b0; bz[i] = 1'b0; li[i] = 0;
        end
    endtask

    task automatic add_vector(input int s, input int len);
        for (int j = 0; j < len; j++) begin
            bv[s+j] = 1'b1;
            li[s+j] = j;
        end
        bl[s+len-1] = 1'b1;
        for (int j = s; j < s + len + TAIL; j++) bz[j] = 1'b1;
    endtask

    function automatic logic [SW-1:0] exp_strobes(input int a, input bit stl);
        logic [NUM_CH-1:0] iv, il, ov, ol;
        iv = '0; il = '0; ov = '0; ol = '0;
        if (!stl) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (a - k >= 0) begin
                    iv[k] = bv[a-k]; il[k] = bl[a-k];
                end
                if (a - k - PIPE_LAT >= 0) begin
                    ov[k] = bv[a-k-PIPE_LAT]; ol[k] = bl[a-k-PIPE_LAT];
                end
            end
        end
        return {ol, ov, il, iv};
    endfunction

    function automatic logic [SW-1:0] got_strobes();
        return {bus.data_out_last, bus.data_out_valid, bus.data_in_last, bus.data_in_valid};
    endfunction

    task automatic test_reset();
        bus.device_in_valid = 1'b0;
        bus.stall           = 1'b0;
        bus.cfg_len         = '0;
        #12;
        checks++;
        if (got_strobes() !== '0 || bus.busy !== 1'b0 || bus.last_count !== '0) begin
            errors++;
            $display("FAIL reset_state got strobes=%h busy=%b lc=%0d exp 0/0/0", got_strobes(), bus.busy, bus.last_count);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (got_strobes() !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got strobes=%h busy=%b exp 0/0", got_strobes(), bus.busy);
        end
        exp_lc = 0;
        #1;
    endtask

    task automatic test_single();
        int a = 0;
        clear_model();
        add_vector(1, 5);
        for (int c = 0; c < 14; c++) begin
            bus.device_in_valid = (c == 0);
            bus.cfg_len         = CNT_W'(5);
            bus.stall           = 1'b0;
            #1;
            if (bv[a]) exp_lc = li[a];
            checks++;
            if (got_strobes() !== exp_strobes(a, 1'b0)) begin
                errors++;
                $display("FAIL single strobes c=%0d got=%h exp=%h", c, got_strobes(), exp_strobes(a, 1'b0));
            end
            checks++;
            if (bus.busy !== bz[a]) begin
                errors++;
                $display("FAIL single busy c=%0d got=%b exp=%b", c, bus.busy, bz[a]);
            end
            checks++;
            if (bus.last_count !== CNT_W'(exp_lc)) begin
                errors++;
                $display("FAIL single last_count c=%0d got=%0d exp=%0d", c, bus.last_count, exp_lc);
            end
            a++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int a = 0;
        clear_model();
        add_vector(1, 4);
        add_vector(5, 4);
        add_vector(9, 4);
        for (int c = 0; c < 21; c++) begin
            bus.device_in_valid = (c <= 8);
            bus.cfg_len         = CNT_W'(4);
            bus.stall           = 1'b0;
            #1;
            if (bv[a]) exp_lc = li[a];
            checks++;
            if (got_strobes() !== exp_strobes(a, 1'b0)) begin
                errors++;
                $display("FAIL back_to_back strobes c=%0d got=%h exp=%h", c, got_strobes(), exp_strobes(a, 1'b0));
            end
            checks++;
            if (bus.busy !== bz[a]) begin
                errors++;
                $display("FAIL back_to_back busy c=%0d got=%b exp=%b", c, bus.busy, bz[a]);
            end
            checks++;
            if (bus.last_count !== CNT_W'(exp_lc)) begin
                errors++;
                $display("FAIL back_to_back last_count c=%0d got=%0d exp=%0d", c, bus.last_count, exp_lc);
            end
            a++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_len_one();
        int a = 0;
        clear_model();
        add_vector(1, 1);
        add_vector(2, 1);
        add_vector(3, 1);
        for (int c = 0; c < 12; c++) begin
            bus.device_in_valid = (c <= 2);
            bus.cfg_len         = CNT_W'(1);
            bus.stall           = 1'b0;
            #1;
            if (bv[a]) exp_lc = li[a];
            checks++;
            if (got_strobes() !== exp_strobes(a, 1'b0)) begin
                errors++;
                $display("FAIL len_one strobes c=%0d got=%h exp=%h", c, got_strobes(), exp_strobes(a, 1'b0));
            end
            checks++;
            if (bus.busy !== bz[a] || bus.last_count !== CNT_W'(exp_lc)) begin
                errors++;
                $display("FAIL len_one busy/lc c=%0d got=%b/%0d exp=%b/%0d", c, bus.busy, bus.last_count, bz[a], exp_lc);
            end
            a++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int a = 0;
        clear_model();
        add_vector(1, 6);
        for (int c = 0; c < 17; c++) begin
            bus.device_in_valid = (c == 0);
            bus.cfg_len         = CNT_W'(6);
            bus.stall           = (c == 4 || c == 5);
            #1;
            if (bv[a]) exp_lc = li[a];
            checks++;
            if (got_strobes() !== exp_strobes(a, bus.stall)) begin
                errors++;
                $display("FAIL stall strobes c=%0d got=%h exp=%h", c, got_strobes(), exp_strobes(a, bus.stall));
            end
            checks++;
            if (bus.busy !== bz[a]) begin
                errors++;
                $display("FAIL stall busy c=%0d got=%b exp=%b", c, bus.busy, bz[a]);
            end
            checks++;
            if (bus.last_count !== CNT_W'(exp_lc)) begin
                errors++;
                $display("FAIL stall last_count c=%0d got=%0d exp=%0d", c, bus.last_count, exp_lc);
            end
            if (!bus.stall) a++;
            @(posedge clk); #1;
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_zero_clamp();
        int a = 0;
        clear_model();
        for (int c = 0; c < 4; c++) begin
            bus.device_in_valid = 1'b1;
            bus.cfg_len         = '0;
            bus.stall           = 1'b0;
            #1;
            checks++;
            if (got_strobes() !== '0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_len c=%0d got strobes=%h busy=%b exp 0/0", c, got_strobes(), bus.busy);
            end
            @(posedge clk); #1;
        end
        add_vector(1, 16);
        for (int c = 0; c < 25; c++) begin
            bus.device_in_valid = (c == 0);
            bus.cfg_len         = CNT_W'(20);
            bus.stall           = 1'b0;
            #1;
            if (bv[a]) exp_lc = li[a];
            checks++;
            if (got_strobes() !== exp_strobes(a, 1'b0)) begin
                errors++;
                $display("FAIL clamp strobes c=%0d got=%h exp=%h", c, got_strobes(), exp_strobes(a, 1'b0));
            end
            checks++;
            if (bus.busy !== bz[a] || bus.last_count !== CNT_W'(exp_lc)) begin
                errors++;
                $display("FAIL clamp busy/lc c=%0d got=%b/%0d exp=%b/%0d", c, bus.busy, bus.last_count, bz[a], exp_lc);
            end
            a++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int a = 0;
        clear_model();
        add_vector(1, 5);
        for (int c = 0; c < 5; c++) begin
            bus.device_in_valid = (c == 0);
            bus.cfg_len         = CNT_W'(5);
            bus.stall           = 1'b0;
            #1;
            if (bv[a]) exp_lc = li[a];
            checks++;
            if (got_strobes() !== exp_strobes(a, 1'b0) || bus.last_count !== CNT_W'(exp_lc)) begin
                errors++;
                $display("FAIL pre_reset c=%0d got=%h/%0d exp=%h/%0d", c, got_strobes(), bus.last_count, exp_strobes(a, 1'b0), exp_lc);
            end
            a++;
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b0;
        #1;
        exp_lc = 0;
        checks++;
        if (got_strobes() !== '0 || bus.busy !== 1'b0 || bus.last_count !== '0) begin
            errors++;
            $display("FAIL async_reset got strobes=%h busy=%b lc=%0d exp 0/0/0", got_strobes(), bus.busy, bus.last_count);
        end
        bus.device_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (got_strobes() !== '0 || bus.busy !== 1'b0 || bus.last_count !== '0) begin
                errors++;
                $display("FAIL post_reset c=%0d got strobes=%h busy=%b lc=%0d exp 0/0/0", c, got_strobes(), bus.busy, bus.last_count);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain_repulse();
        int a = 0;
        clear_model();
        add_vector(1, 5);
        add_vector(14, 2);
        for (int c = 0; c < 24; c++) begin
            bus.device_in_valid = (c <= 2) || (c == 7) || (c == 13);
            bus.cfg_len         = (c == 13) ? CNT_W'(2) : CNT_W'(5);
            bus.stall           = 1'b0;
            #1;
            if (bv[a]) exp_lc = li[a];
            checks++;
            if (got_strobes() !== exp_strobes(a, 1'b0)) begin
                errors++;
                $display("FAIL drain_repulse strobes c=%0d got=%h exp=%h", c, got_strobes(), exp_strobes(a, 1'b0));
            end
            checks++;
            if (bus.busy !== bz[a]) begin
                errors++;
                $display("FAIL drain_repulse busy c=%0d got=%b exp=%b", c, bus.busy, bz[a]);
            end
            checks++;
            if (bus.last_count !== CNT_W'(exp_lc)) begin
                errors++;
                $display("FAIL drain_repulse last_count c=%0d got=%0d exp=%0d", c, bus.last_count, exp_lc);
            end
            a++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_len_one();
        test_stall();
        test_zero_clamp();
        test_reset_mid();
        test_drain_repulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
